// File: rtl/dual_port_ram.sv
// True dual-port synchronous RAM, one clock, registered read outputs, port A wins address collisions.
// Optional macro DUAL_PORT_RAM_WRITE_FIRST_EN selects write-first reads instead of read-before-write.
module dual_port_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_a,
    input  logic              we_b,
    input  logic              re_a,
    input  logic              re_b,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    input  logic [ADDR_W-1:0] add_a,
    input  logic [ADDR_W-1:0] add_b,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_b_ok;
    logic              load_a;
    logic              load_b;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    assign wr_b_ok = we_b && !(we_a && (add_a == add_b));

`ifdef DUAL_PORT_RAM_WRITE_FIRST_EN
    // Read data is the word the array will hold after this edge, so a
    // same-address collision forwards port A's data on both ports.
    always_comb begin
        rd_a   = mem[add_a];
        rd_b   = mem[add_b];
        load_a = re_a;
        load_b = re_b;
        if (wr_b_ok && (add_b == add_a))
            rd_a = data_b;
        if (we_a)
            rd_a = data_a;
        if (we_a && (add_a == add_b))
            rd_b = data_a;
        else if (we_b)
            rd_b = data_b;
    end
`else
    always_comb begin
        rd_a   = mem[add_a];
        rd_b   = mem[add_b];
        load_a = re_a && !we_a;
        load_b = re_b && !we_b;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            out_a <= '0;
            out_b <= '0;
        end else begin
            if (we_a)
                mem[add_a] <= data_a;
            if (wr_b_ok)
                mem[add_b] <= data_b;
            if (load_a)
                out_a <= rd_a;
            if (load_b)
                out_b <= rd_b;
        end
    end

endmodule

// File: tb/tb_dual_port_ram.sv
// Scoreboard bench for dual_port_ram: stimulus pushes expected outputs per cycle,
// a monitor pops and compares after each rising edge.
module tb_dual_port_ram;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       we_a = 1'b0, we_b = 1'b0, re_a = 1'b0, re_b = 1'b0;
    logic [7:0] data_a = '0, data_b = '0;
    logic [3:0] add_a = '0, add_b = '0;
    logic [7:0] out_a, out_b;

    dual_port_ram dut (
        .clk(clk), .rst(rst),
        .we_a(we_a), .we_b(we_b), .re_a(re_a), .re_b(re_b),
        .data_a(data_a), .data_b(data_b),
        .add_a(add_a), .add_b(add_b),
        .out_a(out_a), .out_b(out_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        string      tag;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad = 0;
    bit   [7:0] ref_mem [16];
    bit   [7:0] ref_a = 0, ref_b = 0;

    // Reference: apply cycle semantics to an array, push the outputs expected after the edge.
    task automatic step(input bit r, input bit wa, input bit wb, input bit ra, input bit rb,
                        input bit [7:0] da, input bit [7:0] db,
                        input bit [3:0] aa, input bit [3:0] ab, input string tag);
        bit [7:0] old_mem [16];
        exp_t     e;
        @(negedge clk);
        rst = r; we_a = wa; we_b = wb; re_a = ra; re_b = rb;
        data_a = da; data_b = db; add_a = aa; add_b = ab;
        if (r) begin
            foreach (ref_mem[i]) ref_mem[i] = 0;
            ref_a = 0;
            ref_b = 0;
        end else begin
            old_mem = ref_mem;
            if (wb) ref_mem[ab] = db;
            if (wa) ref_mem[aa] = da;
`ifdef DUAL_PORT_RAM_WRITE_FIRST_EN
            if (ra) ref_a = ref_mem[aa];
            if (rb) ref_b = ref_mem[ab];
`else
            if (ra && !wa) ref_a = old_mem[aa];
            if (rb && !wb) ref_b = old_mem[ab];
`endif
        end
        e.a = ref_a;
        e.b = ref_b;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic idle(input string tag);
        step(0, 0, 0, 0, 0, 8'h00, 8'h00, 4'd0, 4'd0, tag);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                total++;
                if (out_a !== e.a) begin
                    bad++;
                    $display("FAIL %s out_a: got %h expected %h", e.tag, out_a, e.a);
                end
                total++;
                if (out_b !== e.b) begin
                    bad++;
                    $display("FAIL %s out_b: got %h expected %h", e.tag, out_b, e.b);
                end
            end
        end
    end

    initial begin : stimulus
        step(1, 0, 0, 0, 0, 8'h00, 8'h00, 4'd0, 4'd0, "init_rst");
        for (int i = 0; i < 16; i++)
            step(0, 1, 0, 0, 0, 8'($urandom_range(1, 255)), 8'h00, 4'(i), 4'd0, "fill");
        for (int i = 0; i < 5; i++)
            step(1, 1, 1, 1, 1, 8'hFF, 8'hEE, 4'(i), 4'(i), "in_rst");
        for (int i = 0; i < 16; i++)
            step(0, 0, 0, 1, 1, 8'h00, 8'h00, 4'(i), 4'(15 - i), "rd_after_rst");

        step(0, 1, 0, 0, 0, 8'h5A, 8'h00, 4'd3, 4'd0, "a_wr3");
        step(0, 1, 0, 0, 1, 8'hC3, 8'h00, 4'd15, 4'd3, "a_wr15_b_rd3");
        step(0, 0, 0, 0, 1, 8'h00, 8'h00, 4'd0, 4'd15, "b_rd15");

        step(0, 0, 1, 0, 0, 8'h00, 8'h7E, 4'd0, 4'd9, "b_wr9");
        step(0, 0, 0, 1, 0, 8'h00, 8'h00, 4'd9, 4'd0, "a_rd9");
        step(0, 0, 0, 0, 0, 8'h00, 8'h00, 4'd2, 4'd0, "a_hold");
        step(0, 0, 0, 0, 0, 8'h00, 8'h00, 4'd5, 4'd0, "a_hold2");

        step(0, 1, 1, 0, 0, 8'h11, 8'h22, 4'd4, 4'd4, "collide4");
        step(0, 0, 0, 1, 1, 8'h00, 8'h00, 4'd4, 4'd4, "rd_collide4");

        step(0, 1, 0, 0, 0, 8'hAA, 8'h00, 4'd6, 4'd0, "a_wr6");
        step(0, 1, 0, 0, 1, 8'hBB, 8'h00, 4'd6, 4'd6, "rw_conflict6");
        step(0, 0, 0, 1, 1, 8'h00, 8'h00, 4'd6, 4'd6, "rd6_after");

        // Same-port write+read and a collision with both ports reading.
        step(0, 1, 0, 1, 0, 8'h3C, 8'h00, 4'd7, 4'd0, "a_wr_rd7");
        step(0, 1, 1, 1, 1, 8'h44, 8'h55, 4'd8, 4'd8, "collide_rd8");
        step(0, 0, 0, 1, 1, 8'h00, 8'h00, 4'd7, 4'd8, "rd7_8");

        for (int i = 0; i < 20; i++)
            step(0, 1, 1, 0, 0, 8'($urandom), 8'($urandom),
                 4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)), "soak_wr");
        for (int i = 0; i < 20; i++)
            step(0, 0, 0, 1, 1, 8'h00, 8'h00,
                 4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)), "soak_rd");
        for (int i = 0; i < 40; i++)
            step(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 8'($urandom), 8'($urandom), 4'($urandom_range(0, 3)),
                 4'($urandom_range(0, 3)), "soak_mix");

        step(1, 1, 1, 0, 0, 8'h99, 8'h98, 4'd1, 4'd2, "rst_mid_burst");
        step(0, 0, 0, 1, 1, 8'h00, 8'h00, 4'd1, 4'd2, "rd_after_mid_rst");

        idle("drain");
        @(negedge clk);
        @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending entries expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
